// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// Bit-period prescaler: counts 0..P-1 (P = max(presc,1)) and ticks on the last count.
module uart_baud_prescaler #(
   parameter int PRESC_W = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clr,
   input  logic               i_en,
   input  logic [PRESC_W-1:0] i_presc,
   output logic               o_bit_tick
);

   logic [PRESC_W-1:0] r_cnt;
   logic [PRESC_W-1:0] w_last;

   assign w_last     = (i_presc == '0) ? '0 : i_presc - PRESC_W'(1);
   assign o_bit_tick = i_en && (r_cnt == w_last);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_bit_tick ? '0 : r_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable width, parity, stop bits and prescaler.
// A one-word holding register lets consecutive frames go out with no idle gap.
//
// state     | meaning
// TX_IDLE   | line high, waiting for the holding register to fill
// TX_START  | start bit (line low) for one bit period
// TX_DATA   | payload bits, LSB first
// TX_PARITY | parity bit, only when enabled for this frame
// TX_STOP   | one or two stop bits; reloads straight into TX_START if a word waits
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESC_W-1:0]    PRESCALE,
   input  logic                  DATA_VALID,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_READY,
   output logic                  Busy,
   output logic                  TX_OUT
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   tx_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_hold;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_en;
   logic                  r_par_bit;
   logic                  r_stop2;
   logic [PRESC_W-1:0]    r_presc;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic                  r_stop_cnt;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_ready;

   logic w_tick;
   logic w_accept;
   logic w_last_stop;
   logic w_load;
   logic w_go_idle;
   logic w_full_next;

   assign w_accept    = DATA_VALID && r_ready;
   assign w_last_stop = (r_state == TX_STOP) && w_tick && (r_stop_cnt == r_stop2);
   assign w_load      = r_full && ((r_state == TX_IDLE) || w_last_stop);
   assign w_go_idle   = !r_full && ((r_state == TX_IDLE) || w_last_stop);
   assign w_full_next = w_accept || (r_full && !w_load);

   uart_baud_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_clr      (w_load),
      .i_en       (r_state != TX_IDLE),
      .i_presc    (r_presc),
      .o_bit_tick (w_tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= TX_IDLE;
         r_hold     <= '0;
         r_full     <= 1'b0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_stop2    <= 1'b0;
         r_presc    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_full  <= w_full_next;
         r_ready <= !w_full_next;
         r_busy  <= w_full_next || !w_go_idle;
         if (w_accept) r_hold <= P_DATA;

         // Config is latched here so mid-frame changes only affect the next frame.
         if (w_load) begin
            r_shift    <= r_hold;
            r_par_en   <= PAR_EN;
            r_stop2    <= STOP2;
            r_presc    <= PRESCALE;
            r_par_bit  <= calc_parity(9'(r_hold), PAR_TYP == PAR_ODD);
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= TX_START;
            r_tx       <= 1'b0;
         end else if (w_tick) begin
            unique case (r_state)
               TX_START: begin
                  r_state <= TX_DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
               TX_DATA: begin
                  if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                     r_state <= r_par_en ? TX_PARITY : TX_STOP;
                     r_tx    <= r_par_en ? r_par_bit : 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end
               TX_PARITY: begin
                  r_state <= TX_STOP;
                  r_tx    <= 1'b1;
               end
               TX_STOP: begin
                  if (w_last_stop) r_state <= TX_IDLE;
                  else             r_stop_cnt <= 1'b1;
               end
               default: begin
                  r_state <= TX_IDLE;
                  r_tx    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign DATA_READY = r_ready;
   assign Busy       = r_busy;
   assign TX_OUT     = r_tx;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: per-cycle comparison against a frame-schedule
// model, a table of single-frame configurations, and hand-written corner sequences.
module tb_uart_tx_cfg;

   localparam int DW   = 8;
   localparam int PW   = 6;
   localparam int MAXE = 8192;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0, DATA_VALID = 1'b0;
   logic [PW-1:0] PRESCALE = '0;
   logic [DW-1:0] P_DATA = '0;
   logic          DATA_READY, Busy, TX_OUT;

   logic          v5 = 1'b0;
   logic [4:0]    d5 = '0;
   logic          ready5, busy5, tx5;

   uart_tx_cfg #(.DATA_WIDTH(DW), .PRESC_W(PW)) u_dut (
      .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .PRESCALE(PRESCALE), .DATA_VALID(DATA_VALID), .P_DATA(P_DATA),
      .DATA_READY(DATA_READY), .Busy(Busy), .TX_OUT(TX_OUT));

   uart_tx_cfg #(.DATA_WIDTH(5), .PRESC_W(PW)) u_dut5 (
      .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .PRESCALE(PRESCALE), .DATA_VALID(v5), .P_DATA(d5),
      .DATA_READY(ready5), .Busy(busy5), .TX_OUT(tx5));

   always #5 CLK = ~CLK;

   int n_chk = 0, n_err = 0, edge_n = 0;

   // Model: expected line level and "frame active" flag after each clock edge.
   bit exp_line [MAXE];
   bit exp_act  [MAXE];
   bit dut_tx   [MAXE];
   bit dut_busy [MAXE];
   bit m_pend = 0, m_ready = 1, m_acc = 0;
   int m_pend_start = 0, m_end = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
      end
   endtask

   task automatic schedule(input int s, output int len_cycles);
      bit fb [16];
      int p, l, k;
      p = (PRESCALE == 0) ? 1 : int'(PRESCALE);
      l = 1 + DW + int'(PAR_EN) + 1 + int'(STOP2);
      fb[0] = 1'b0;
      for (int i = 0; i < DW; i++) fb[1+i] = P_DATA[i];
      k = 1 + DW;
      if (PAR_EN) begin
         fb[k] = 1'(($countones(P_DATA) % 2) ^ int'(PAR_TYP));
         k++;
      end
      fb[k] = 1'b1;
      if (STOP2) fb[k+1] = 1'b1;
      for (int b = 0; b < l; b++)
         for (int j = 0; j < p; j++)
            if (s + b*p + j < MAXE) begin
               exp_line[s + b*p + j] = fb[b];
               exp_act[s + b*p + j]  = 1'b1;
            end
      len_cycles = l * p;
   endtask

   task automatic model_edge();
      int e, s, len;
      e = edge_n;
      m_acc = 0;
      if (RST) begin
         for (int x = e; x < MAXE; x++) begin
            exp_line[x] = 1'b1;
            exp_act[x]  = 1'b0;
         end
         m_pend = 0; m_end = e; m_ready = 1;
      end else begin
         if (m_pend && m_pend_start == e) m_pend = 0;
         if (DATA_VALID && m_ready) begin
            m_acc = 1;
            s = (m_end > e + 1) ? m_end : e + 1;
            schedule(s, len);
            m_end = s + len;
            m_pend = 1;
            m_pend_start = s;
         end
         m_ready = !m_pend;
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      edge_n++;
      if (edge_n >= MAXE) begin
         $display("FAIL edge_budget exceeded at edge %0d", edge_n);
         $fatal(1, "edge budget exceeded");
      end
      model_edge();
      @(negedge CLK);
      dut_tx[edge_n]   = TX_OUT;
      dut_busy[edge_n] = Busy;
      chk("tx_out",     int'(TX_OUT),     int'(exp_line[edge_n]));
      chk("busy",       int'(Busy),       int'(m_pend || exp_act[edge_n]));
      chk("data_ready", int'(DATA_READY), int'(m_ready));
   endtask

   task automatic send(input logic [DW-1:0] d, output int acc_edge);
      P_DATA = d;
      DATA_VALID = 1'b1;
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (m_acc) break;
      end
      if (!m_acc) begin
         n_chk++; n_err++;
         $display("FAIL accept_timeout: got no accept expected accept within 400 cycles");
      end
      acc_edge = edge_n;
      DATA_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         if (!m_pend && m_end <= edge_n) return;
         cycle();
      end
      n_chk++; n_err++;
      $display("FAIL idle_timeout: got busy expected idle within 3000 cycles");
   endtask

   function automatic int flen_at(input int s);
      int n = 0;
      while (s + n < MAXE && dut_busy[s+n] && n < 2000) n++;
      return n;
   endfunction

   typedef struct {
      logic [7:0] data;
      bit         pe, pt, s2;
      int         presc;
      int         flen;
      int         parbit;
   } vec_t;

   initial #400000 begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [7];
      int acc, acc2, s, s1, s2, p, lows;
      logic [9:0] pat;
      logic [7:0] exp5;

      vecs[0] = '{8'hA5, 0, 0, 0, 4, 40, -1};
      vecs[1] = '{8'h07, 1, 0, 0, 4, 44,  1};
      vecs[2] = '{8'h07, 1, 1, 0, 4, 44,  0};
      vecs[3] = '{8'h07, 1, 0, 1, 4, 48,  1};
      vecs[4] = '{8'h00, 0, 0, 1, 0, 11, -1};
      vecs[5] = '{8'hFF, 1, 1, 0, 2, 22,  1};
      vecs[6] = '{8'h3C, 1, 0, 1, 5, 60,  0};

      for (int x = 0; x < MAXE; x++) exp_line[x] = 1'b1;

      RST = 1'b1;
      cycle();
      cycle();
      chk("reset_tx", int'(TX_OUT), 1);
      chk("reset_busy", int'(Busy), 0);
      chk("reset_ready", int'(DATA_READY), 1);
      chk("reset_ready5", int'(ready5), 1);
      RST = 1'b0;
      cycle();

      // Basic 0xA5 frame, waveform against the literal bit pattern.
      PRESCALE = PW'(4);
      send(8'hA5, acc);
      wait_idle();
      s = acc + 1;
      pat = 10'b1101001010;
      for (int b = 0; b < 10; b++) chk("a5_bit", int'(dut_tx[s + 4*b + 2]), int'(pat[b]));
      chk("a5_len", flen_at(s), 40);
      cycle();

      foreach (vecs[i]) begin
         PAR_EN = vecs[i].pe; PAR_TYP = vecs[i].pt; STOP2 = vecs[i].s2;
         PRESCALE = PW'(vecs[i].presc);
         send(vecs[i].data, acc);
         wait_idle();
         s = acc + 1;
         p = (vecs[i].presc == 0) ? 1 : vecs[i].presc;
         chk("vec_start_bit", int'(dut_tx[s]), 0);
         chk("vec_frame_len", flen_at(s), vecs[i].flen);
         if (vecs[i].parbit >= 0) chk("vec_parity", int'(dut_tx[s + 9*p]), vecs[i].parbit);
         cycle();
      end

      // Back-to-back: second start bit directly follows the first frame's last stop cycle.
      PAR_EN = 0; PAR_TYP = 0; STOP2 = 0; PRESCALE = PW'(4);
      send(8'h11, acc);
      send(8'h22, acc2);
      wait_idle();
      s1 = acc + 1;
      s2 = s1 + 40;
      chk("b2b_accept2_edge", acc2, acc + 2);
      chk("b2b_last_stop", int'(dut_tx[s2-1]), 1);
      chk("b2b_second_start", int'(dut_tx[s2]), 0);
      chk("b2b_busy_gap", int'(dut_busy[s2]), 1);
      chk("b2b_busy_end", int'(dut_busy[s2+40]), 0);
      cycle();

      // Config change during DATA affects only the next frame.
      PRESCALE = PW'(3);
      send(8'h5A, acc);
      repeat (15) cycle();
      PAR_EN = 1; PRESCALE = PW'(2);
      wait_idle();
      chk("cfg_frame1_len", flen_at(acc + 1), 30);
      cycle();
      send(8'h5A, acc2);
      wait_idle();
      chk("cfg_frame2_len", flen_at(acc2 + 1), 22);
      cycle();

      // Width-5 instance, PRESCALE=0 means one cycle per bit.
      PAR_EN = 0; STOP2 = 0; PRESCALE = '0;
      v5 = 1'b1; d5 = 5'h1F;
      cycle();
      v5 = 1'b0;
      chk("w5_ready_after_accept", int'(ready5), 0);
      chk("w5_busy_after_accept", int'(busy5), 1);
      exp5 = 8'b1111_1110;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("w5_tx", int'(tx5), int'(exp5[i]));
      end
      chk("w5_busy_end", int'(busy5), 0);
      cycle();

      // Reset during DATA bit 3 with a word pending.
      PRESCALE = PW'(4);
      send(8'h11, acc);
      while (edge_n < acc + 1 + 4*4 + 1) cycle();
      send(8'h33, acc2);
      RST = 1'b1;
      cycle();
      chk("rst_mid_tx", int'(TX_OUT), 1);
      chk("rst_mid_busy", int'(Busy), 0);
      chk("rst_mid_ready", int'(DATA_READY), 1);
      RST = 1'b0;
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (!TX_OUT || Busy) lows++;
      end
      chk("rst_no_residual", lows, 0);

      // Randomized traffic; config changes only when no word is waiting to load.
      for (int n = 0; n < 40; n++) begin
         if (!m_pend) begin
            PAR_EN   = 1'($urandom_range(0, 1));
            PAR_TYP  = 1'($urandom_range(0, 1));
            STOP2    = 1'($urandom_range(0, 1));
            PRESCALE = PW'($urandom_range(0, 5));
         end
         repeat ($urandom_range(0, 3)) cycle();
         send(DW'($urandom_range(0, 255)), acc);
      end
      wait_idle();
      repeat (5) cycle();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
